// File: rtl/gol_gen_scheduler.sv
// Game of Life generation pacer: programmable tick enable plus
// start/done sequencing of the grid update engine, all on clk.
module gol_gen_scheduler #(
  parameter int BASE_DIV = 2500000,
  parameter int CNT_W    = 32,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             step_req,
  input  logic [2:0]       speed_sel,
  input  logic             upd_done,
  input  logic             clr_ovr,
  output logic             upd_start,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             ovr
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    UPDATE
  } state_t;

  state_t           state, state_n;
  logic             run_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] reload;
  logic             rise;
  logic             tick;
  logic             start_n;
  logic             gen_inc;
  logic             ovr_set;

  assign base   = CNT_W'(BASE_DIV);
  assign reload = (base << speed_sel) - CNT_W'(1);
  assign rise   = run_en & ~run_q;
  // The rise cycle sees the idle zero count; it must not tick.
  assign tick   = run_en & run_q & (cnt == '0);
  assign busy   = (state == UPDATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt   <= '0;
    end else begin
      run_q <= run_en;
      if (!run_en)
        cnt <= '0;
      else if (rise || cnt == '0)
        cnt <= reload;
      else
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    start_n = 1'b0;
    gen_inc = 1'b0;
    ovr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (run_en) begin
          state_n = WAIT_TICK;
        end else if (step_req) begin
          state_n = UPDATE;
          start_n = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (!run_en) begin
          state_n = IDLE;
        end else if (tick) begin
          state_n = UPDATE;
          start_n = 1'b1;
        end
      end
      UPDATE: begin
        if (upd_done) begin
          gen_inc = 1'b1;
          // A tick landing on done chains straight into the next generation.
          if (tick)
            start_n = 1'b1;
          else if (run_en)
            state_n = WAIT_TICK;
          else
            state_n = IDLE;
        end else if (tick) begin
          ovr_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      upd_start <= 1'b0;
      gen_count <= '0;
      ovr       <= 1'b0;
    end else begin
      state     <= state_n;
      upd_start <= start_n;
      if (gen_inc)
        gen_count <= gen_count + GEN_W'(1);
      if (ovr_set)
        ovr <= 1'b1;
      else if (clr_ovr)
        ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Directed bench for gol_gen_scheduler with a start-time scoreboard.
// GEN_W is reduced so the counter wrap is reachable by stepping.
module tb_gol_gen_scheduler;

  localparam int BD = 4;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_en;
  logic          step_req;
  logic [2:0]    speed_sel;
  logic          upd_done;
  logic          clr_ovr;
  logic          upd_start;
  logic          busy;
  logic [GW-1:0] gen_count;
  logic          ovr;

  logic done_auto = 1'b0;
  logic done_man;
  int   auto_lat = 0;
  int   dcnt = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_q[$];
  logic prev_start = 1'b0;

  assign upd_done = done_auto | done_man;

  gol_gen_scheduler #(
    .BASE_DIV(BD),
    .CNT_W(32),
    .GEN_W(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run_en(run_en),
    .step_req(step_req),
    .speed_sel(speed_sel),
    .upd_done(upd_done),
    .clr_ovr(clr_ovr),
    .upd_start(upd_start),
    .busy(busy),
    .gen_count(gen_count),
    .ovr(ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Update-engine model: done arrives auto_lat edges after each start.
  always @(negedge clk) begin
    done_auto = (dcnt == 1);
    if (dcnt > 0) dcnt--;
    if (upd_start && auto_lat >= 2) dcnt = auto_lat - 1;
  end

  // Every start must match the oldest expected start cycle.
  always @(negedge clk) begin
    if (upd_start) begin
      chk("start_not_back_to_back", {31'd0, prev_start}, 32'd0);
      if (start_q.size() == 0)
        chk("unexpected_start", 32'(cyc), 32'hFFFF_FFFF);
      else
        chk("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
    end
    prev_start = upd_start;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int c0, s, r, q;

  initial begin
    rst_n = 1'b0; run_en = 1'b0; step_req = 1'b0; speed_sel = 3'd0;
    done_man = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    chk("rst_start", {31'd0, upd_start}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous run at speed 0, done 3 cycles after each start
    auto_lat = 3;
    c0 = cyc;
    run_en = 1'b1;
    start_q.push_back(c0 + 5);
    start_q.push_back(c0 + 9);
    start_q.push_back(c0 + 13);
    wait_cyc(c0 + 8);
    chk("run_gen1", 32'(gen_count), 32'd1);
    wait_cyc(c0 + 12);
    chk("run_gen2", 32'(gen_count), 32'd2);
    wait_cyc(c0 + 14);
    speed_sel = 3'd2;
    start_q.push_back(c0 + 17);
    start_q.push_back(c0 + 33);
    start_q.push_back(c0 + 49);
    wait_cyc(c0 + 16);
    chk("run_gen3", 32'(gen_count), 32'd3);
    chk("run_ovr", {31'd0, ovr}, 32'd0);
    wait_cyc(c0 + 53);
    chk("speed2_gen6", 32'(gen_count), 32'd6);
    run_en = 1'b0;
    speed_sel = 3'd0;
    repeat (3) @(negedge clk);
    chk("pause_idle", {31'd0, busy}, 32'd0);

    // Single step while paused; a second step while busy is ignored
    auto_lat = 6;
    s = cyc;
    step_req = 1'b1;
    start_q.push_back(s + 1);
    @(negedge clk);
    step_req = 1'b0;
    chk("step_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    wait_cyc(s + 5);
    chk("step_still_busy", {31'd0, busy}, 32'd1);
    wait_cyc(s + 8);
    chk("step_done_busy", {31'd0, busy}, 32'd0);
    chk("step_gen", 32'(gen_count), 32'd7);
    auto_lat = 0;
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", 32'(gen_count), 32'd7);

    // Overrun with done withheld, clr/set collision, tick+done chain
    r = cyc;
    run_en = 1'b1;
    start_q.push_back(r + 5);
    wait_cyc(r + 8);
    chk("ovr_before", {31'd0, ovr}, 32'd0);
    wait_cyc(r + 9);
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    wait_cyc(r + 12);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_set_wins", {31'd0, ovr}, 32'd1);
    wait_cyc(r + 14);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_cleared", {31'd0, ovr}, 32'd0);
    done_man = 1'b1;
    start_q.push_back(r + 17);
    @(negedge clk);
    done_man = 1'b0;
    chk("late_done_gen", 32'(gen_count), 32'd8);
    wait_cyc(r + 20);
    done_man = 1'b1;
    start_q.push_back(r + 21);
    @(negedge clk);
    done_man = 1'b0;
    chk("tick_done_gen", 32'(gen_count), 32'd9);
    chk("tick_done_busy", {31'd0, busy}, 32'd1);
    chk("tick_done_ovr", {31'd0, ovr}, 32'd0);
    run_en = 1'b0;
    wait_cyc(r + 23);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    @(negedge clk);
    chk("drop_run_idle", {31'd0, busy}, 32'd0);
    chk("drop_run_gen", 32'(gen_count), 32'd10);

    // Step up to the counter maximum, then wrap
    for (int i = 0; i < 246; i++) begin
      step_req = 1'b1;
      start_q.push_back(cyc + 1);
      @(negedge clk);
      step_req = 1'b0;
      done_man = 1'b1;
      @(negedge clk);
      done_man = 1'b0;
      @(negedge clk);
      if (i == 244) chk("gen_max", 32'(gen_count), 32'hFF);
    end
    chk("gen_wrap", 32'(gen_count), 32'd0);
    step_req = 1'b1;
    start_q.push_back(cyc + 1);
    @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);

    // Reset in UPDATE, then a stale done
    q = cyc;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_gen", 32'(gen_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_done_busy", {31'd0, busy}, 32'd0);
    chk("stale_done_gen", 32'(gen_count), 32'd0);
    chk("start_q_empty", 32'(start_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
